// File: rtl/oam_dma_if.sv
// CPU-side and system-bus-side signal bundle for the sprite DMA engine.
interface oam_dma_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_o;
    logic        cpu_r;
    logic        cpu_w;
    logic [7:0]  bus_i;
    logic [15:0] bus_a;
    logic [7:0]  bus_o;
    logic        bus_r;
    logic        bus_w;

    modport master (
        output cpu_a, cpu_o, cpu_r, cpu_w, bus_i,
        input  bus_a, bus_o, bus_r, bus_w
    );

    modport slave (
        input  cpu_a, cpu_o, cpu_r, cpu_w, bus_i,
        output bus_a, bus_o, bus_r, bus_w
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA at $4014: stalls the CPU and copies one page to OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert the get/put alignment tick (513/514).
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004,
    parameter int          LEN      = 256
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     ce,
    oam_dma_if.slave bif,
    output logic     ce_cpu,
    output logic     busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
    logic       w_trig;

    assign w_trig = (r_state == S_IDLE) && bif.cpu_w
                 && (bif.cpu_a == DMA_REG);

`ifdef OAM_DMA_ALIGN_EN
    // 0 = get (read) slot, 1 = put (write) slot
    logic r_parity;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (ce) begin
            r_parity <= ~r_parity;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
        end else if (ce) begin
            r_state <= w_next;
            if (w_trig) begin
                r_page <= bif.cpu_o;
                r_idx  <= 8'h00;
            end
            if (r_state == S_READ) begin
                r_latch <= bif.bus_i;
            end
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 8'h01;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        ce_cpu    = ce;
        bif.bus_a = bif.cpu_a;
        bif.bus_o = bif.cpu_o;
        bif.bus_r = bif.cpu_r;
        bif.bus_w = bif.cpu_w;
        // Any non-idle state owns the bus; strobes are enabled per state
        if (r_state != S_IDLE) begin
            busy      = 1'b1;
            ce_cpu    = 1'b0;
            bif.bus_a = {r_page, r_idx};
            bif.bus_o = r_latch;
            bif.bus_r = 1'b0;
            bif.bus_w = 1'b0;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_next = S_HALT;
                end
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                w_next = r_parity ? S_READ : S_ALIGN;
`else
                w_next = S_READ;
`endif
            end
            S_ALIGN: begin
                w_next = S_READ;
            end
            S_READ: begin
                bif.bus_r = ce;
                w_next    = S_WRITE;
            end
            S_WRITE: begin
                bif.bus_a = OAM_PORT;
                bif.bus_w = ce;
                w_next    = (r_idx == LAST) ? S_IDLE : S_READ;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected reads/writes queued per trigger.
module tb_oam_dma;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce      = 1'b0;
    logic       ce_cpu;
    logic       busy;
    logic [7:0] key     = 8'h00;

    int checks     = 0;
    int failures   = 0;
    int stolen     = 0;
    int strobe_bad = 0;

    logic [15:0] exp_rd[$];
    logic [23:0] exp_wr[$];
    logic [15:0] obs_rd[$];
    logic [23:0] obs_wr[$];

    oam_dma_if bif();

    assign bif.bus_i = bif.bus_a[7:0] ^ key;

    oam_dma dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ce     (ce),
        .bif    (bif),
        .ce_cpu (ce_cpu),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n) begin
            if (ce && !ce_cpu) stolen++;
            if (busy && ce && bif.bus_r) obs_rd.push_back(bif.bus_a);
            if (busy && ce && bif.bus_w) obs_wr.push_back({bif.bus_a, bif.bus_o});
            if (busy && !ce && (bif.bus_r || bif.bus_w)) strobe_bad++;
        end
    end

    task automatic tick(input logic c);
        ce = c;
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_idle();
        bif.cpu_a = 16'h0000;
        bif.cpu_o = 8'h00;
        bif.cpu_r = 1'b0;
        bif.cpu_w = 1'b0;
    endtask

    task automatic do_reset();
        cpu_idle();
        ce      = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_xfer(input logic [7:0] page, input logic [7:0] k,
                            input int div, input int exp_stolen,
                            input string nm, output int clks);
        int s0, r0, w0;
        logic [15:0] gr, er;
        logic [23:0] gw, ew;
        s0  = stolen;
        r0  = obs_rd.size();
        w0  = obs_wr.size();
        key = k;
        for (int i = 0; i < 256; i++) begin
            exp_rd.push_back({page, 8'(i)});
            exp_wr.push_back({16'h2004, 8'(i) ^ k});
        end
        bif.cpu_a = 16'h4014;
        bif.cpu_o = page;
        bif.cpu_r = 1'b0;
        bif.cpu_w = 1'b1;
        #1;
        checks++;
        if (bif.bus_w !== 1'b1 || bif.bus_a !== 16'h4014) begin
            failures++;
            $display("FAIL %s trig_pass got a=%h w=%b exp a=4014 w=1", nm, bif.bus_a, bif.bus_w);
        end
        tick(1'b1);
        cpu_idle();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_rise got=%b exp=1", nm, busy);
        end
        clks = 0;
        while (busy === 1'b1 && clks < 5000) begin
            clks++;
            tick((clks % div) == 0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout busy got=%b exp=0", nm, busy);
        end
        checks++;
        if (stolen - s0 != exp_stolen) begin
            failures++;
            $display("FAIL %s stolen got=%0d exp=%0d", nm, stolen - s0, exp_stolen);
        end
        checks++;
        if (obs_rd.size() - r0 != 256 || obs_wr.size() - w0 != 256) begin
            failures++;
            $display("FAIL %s count got rd=%0d wr=%0d exp=256", nm,
                     obs_rd.size() - r0, obs_wr.size() - w0);
        end
        for (int i = 0; i < 256; i++) begin
            er = exp_rd.pop_front();
            ew = exp_wr.pop_front();
            gr = (r0 + i < obs_rd.size()) ? obs_rd[r0 + i] : 16'hxxxx;
            gw = (w0 + i < obs_wr.size()) ? obs_wr[w0 + i] : 24'hxxxxxx;
            checks++;
            if (gr !== er) begin
                failures++;
                $display("FAIL %s rd[%0d] got=%h exp=%h", nm, i, gr, er);
            end
            checks++;
            if (gw !== ew) begin
                failures++;
                $display("FAIL %s wr[%0d] got=%h exp=%h", nm, i, gw, ew);
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        ce        = 1'b1;
        bif.cpu_a = 16'h4015;
        bif.cpu_o = 8'h3C;
        bif.cpu_r = 1'b1;
        bif.cpu_w = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ce_cpu !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctl got busy=%b ce_cpu=%b exp 0 1", busy, ce_cpu);
        end
        checks++;
        if (bif.bus_a !== 16'h4015 || bif.bus_r !== 1'b1 || bif.bus_o !== 8'h3C) begin
            failures++;
            $display("FAIL reset_pass got a=%h r=%b o=%h exp 4015 1 3c",
                     bif.bus_a, bif.bus_r, bif.bus_o);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int c;
        do_reset();
        run_xfer(8'h03, 8'h3C, 1, 513, "basic", c);
        checks++;
        if (c != 513) begin
            failures++;
            $display("FAIL basic clocks got=%0d exp=513", c);
        end
    endtask

    task automatic test_align();
        int c, e;
`ifdef OAM_DMA_ALIGN_EN
        e = 514;
`else
        e = 513;
`endif
        do_reset();
        tick(1'b1);
        run_xfer(8'h04, 8'hC3, 1, e, "align", c);
    endtask

    task automatic test_data();
        int c;
        do_reset();
        run_xfer(8'h07, 8'hA5, 1, 513, "data_a5", c);
    endtask

    task automatic test_ce_gap();
        int c, sb;
        do_reset();
        sb = strobe_bad;
        run_xfer(8'h02, 8'h96, 4, 513, "ce_gap", c);
        checks++;
        if (c != 4 * 513) begin
            failures++;
            $display("FAIL ce_gap clocks got=%0d exp=%0d", c, 4 * 513);
        end
        checks++;
        if (strobe_bad != sb) begin
            failures++;
            $display("FAIL ce_gap strobe_on_ce0 got=%0d exp=0", strobe_bad - sb);
        end
    endtask

    task automatic test_reset_mid();
        int w0, n, c;
        do_reset();
        key       = 8'h11;
        bif.cpu_a = 16'h4014;
        bif.cpu_o = 8'h05;
        bif.cpu_w = 1'b1;
        tick(1'b1);
        cpu_idle();
        w0 = obs_wr.size();
        n  = 0;
        while (obs_wr.size() - w0 < 100 && n < 1000) begin
            n++;
            tick(1'b1);
        end
        checks++;
        if (obs_wr.size() - w0 != 100) begin
            failures++;
            $display("FAIL mid_progress got=%0d exp=100", obs_wr.size() - w0);
        end
        @(negedge clock);
        bif.cpu_a = 16'h1234;
        bif.cpu_o = 8'h77;
        bif.cpu_r = 1'b1;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ce_cpu !== ce) begin
            failures++;
            $display("FAIL mid_reset_ctl got busy=%b ce_cpu=%b exp 0 %b", busy, ce_cpu, ce);
        end
        checks++;
        if (bif.bus_a !== 16'h1234 || bif.bus_r !== 1'b1 || bif.bus_w !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_pass got a=%h r=%b w=%b exp 1234 1 0",
                     bif.bus_a, bif.bus_r, bif.bus_w);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cpu_idle();
        run_xfer(8'h06, 8'h5A, 1, 513, "restart", c);
    endtask

    task automatic test_idle_pass();
        int s0;
        do_reset();
        s0        = stolen;
        bif.cpu_a = 16'h4014;
        bif.cpu_r = 1'b1;
        #1;
        checks++;
        if (bif.bus_a !== 16'h4014 || bif.bus_r !== 1'b1 || bif.bus_w !== 1'b0) begin
            failures++;
            $display("FAIL idle_rd got a=%h r=%b w=%b exp 4014 1 0",
                     bif.bus_a, bif.bus_r, bif.bus_w);
        end
        tick(1'b1);
        bif.cpu_a = 16'h4015;
        bif.cpu_o = 8'h1F;
        bif.cpu_r = 1'b0;
        bif.cpu_w = 1'b1;
        #1;
        checks++;
        if (bif.bus_a !== 16'h4015 || bif.bus_w !== 1'b1 || bif.bus_o !== 8'h1F) begin
            failures++;
            $display("FAIL idle_wr got a=%h w=%b o=%h exp 4015 1 1f",
                     bif.bus_a, bif.bus_w, bif.bus_o);
        end
        tick(1'b1);
        cpu_idle();
        tick(1'b1);
        checks++;
        if (busy !== 1'b0 || ce_cpu !== 1'b1 || stolen != s0) begin
            failures++;
            $display("FAIL idle_nodma got busy=%b ce_cpu=%b stolen=%0d exp 0 1 0",
                     busy, ce_cpu, stolen - s0);
        end
    endtask

    initial begin
        cpu_idle();
        test_reset();
        test_basic();
        test_align();
        test_data();
        test_ce_gap();
        test_reset_mid();
        test_idle_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
